// File: rtl/sa_skew_feeder.sv
// Operand feeder for an N x N systolic array: buffers A and B, then streams
// A rows and B columns into the array edges with diagonal skew.
module sa_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic            ld_sel,
    input  logic [IW-1:0]   ld_row,
    input  logic [IW-1:0]   ld_col,
    input  logic [DW-1:0]   ld_data,
    input  logic            start,
    output logic            pe_clr,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic            busy,
    output logic            done
);

    localparam int TW = $clog2(3 * N);
    // One trailing all-zero cycle follows t = 3N-3 so PE(N-1,N-1) can
    // accumulate its final product before done is raised.
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 2);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

    state_t            state_q, state_nxt;
    logic [TW-1:0]     t_q, t_nxt;
    logic [N*DW-1:0]   a_nxt, b_nxt;
    logic [DW-1:0]     a_mem [N][N];
    logic [DW-1:0]     b_mem [N][N];
    logic              wr;

    assign wr = ld_valid & ld_ready;

    // NOTE: the operand buffers are reset on purpose -- a run after reset must
    // see zeros, so this storage is flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
            end
        end else if (wr) begin
            // Out-of-range indices match no element and are dropped.
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (ld_row == IW'(i) && ld_col == IW'(j)) begin
                        if (ld_sel) b_mem[i][j] <= ld_data;
                        else        a_mem[i][j] <= ld_data;
                    end
                end
            end
        end
    end

    // NOTE: state and outputs use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            ld_ready <= 1'b0;
            pe_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_edge   <= '0;
            b_edge   <= '0;
        end else begin
            state_q  <= state_nxt;
            t_q      <= t_nxt;
            ld_ready <= (state_nxt == S_IDLE);
            pe_clr   <= (state_nxt == S_CLEAR);
            busy     <= (state_nxt == S_CLEAR) || (state_nxt == S_FEED);
            done     <= (state_nxt == S_DONE);
            a_edge   <= a_nxt;
            b_edge   <= b_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (t_q == T_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming cycle and registered above.
    always_comb begin
        t_nxt = '0;
        a_nxt = '0;
        b_nxt = '0;
        if (state_nxt == S_FEED && state_q == S_FEED)
            t_nxt = t_q + TW'(1);
        if (state_nxt == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (t_nxt == TW'(i + k)) begin
                        a_nxt[i*DW +: DW] = a_mem[i][k];
                        b_nxt[i*DW +: DW] = b_mem[k][i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder with a behavioural 4x4 PE array on the
// edges so full matrix products can be checked against hand-computed results.
module tb_sa_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 3;
    localparam int W  = N * DW;
    localparam int NC = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_sel = 1'b0;
    logic [IW-1:0] ld_row = '0;
    logic [IW-1:0] ld_col = '0;
    logic [DW-1:0] ld_data = '0;
    logic          start = 1'b0;
    logic          ld_ready, pe_clr, busy, done;
    logic [W-1:0]  a_edge, b_edge;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] tr_a [NC];
    logic [W-1:0] tr_b [NC];
    logic         tr_clr  [NC];
    logic         tr_done [NC];
    logic         tr_busy [NC];
    logic         tr_rdy  [NC];
    logic [W-1:0] rst_a, rst_b;
    logic         rst_busy, rst_done;

    int pe_a [N][N];
    int pe_b [N][N];
    int pe_c [N][N];

    sa_skew_feeder #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
        .start(start), .pe_clr(pe_clr), .a_edge(a_edge), .b_edge(b_edge),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // PE(i,j): operands forwarded right/down through one register each.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int ain, bin;
                if (j == 0) ain = int'(a_edge[i*DW +: DW]);
                else        ain = pe_a[i][j-1];
                if (i == 0) bin = int'(b_edge[j*DW +: DW]);
                else        bin = pe_b[i-1][j];
                if (pe_clr) pe_c[i][j] <= 0;
                else        pe_c[i][j] <= pe_c[i][j] + ain * bin;
                pe_a[i][j] <= ain;
                pe_b[i][j] <= bin;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: A=16i+k+1, B=16k+j+1; 1: A=I, B=4k+j; 2: A=2, B=3; 3: zero
    function automatic int a_val(input int mode, input int i, input int k);
        case (mode)
            0: return 16 * i + k + 1;
            1: return (i == k) ? 1 : 0;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int b_val(input int mode, input int k, input int j);
        case (mode)
            0: return 16 * k + j + 1;
            1: return 4 * k + j;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    // Expected edge word in cycle c after start (t = c - 2).
    function automatic logic [W-1:0] exp_a(input int mode, input int c);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            int k = c - 2 - i;
            if (k >= 0 && k < N) r[i*DW +: DW] = DW'(a_val(mode, i, k));
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_b(input int mode, input int c);
        logic [W-1:0] r = '0;
        for (int j = 0; j < N; j++) begin
            int k = c - 2 - j;
            if (k >= 0 && k < N) r[j*DW +: DW] = DW'(b_val(mode, k, j));
        end
        return r;
    endfunction

    task automatic load(input logic sel, input int r, input int c, input int d);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = IW'(r);
        ld_col   = IW'(c);
        ld_data  = DW'(d);
        step;
        ld_valid = 1'b0;
    endtask

    task automatic load_mats(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                load(1'b0, i, j, a_val(mode, i, j));
                load(1'b1, i, j, b_val(mode, i, j));
            end
        end
    endtask

    // Start at cycle 0 and record cycles 1..NC-1.
    task automatic run(input int extra_start, input int rst_at,
                       input bit junk_load, input bit hold_start);
        start = 1'b1;
        for (int c = 1; c < NC; c++) begin
            step;
            tr_a[c] = a_edge;   tr_b[c] = b_edge;
            tr_clr[c] = pe_clr; tr_done[c] = done;
            tr_busy[c] = busy;  tr_rdy[c] = ld_ready;
            start = hold_start || (c == extra_start);
            if (junk_load && c >= 2 && c <= 11) begin
                ld_valid = 1'b1;
                ld_sel   = (c % 2 == 1);
                ld_row   = '0;
                ld_col   = '0;
                ld_data  = 8'hFF;
            end else begin
                ld_valid = 1'b0;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                rst_a = a_edge; rst_b = b_edge;
                rst_busy = busy; rst_done = done;
            end
            if (c == rst_at + 3) rst = 1'b1;
        end
        start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) step;
        n_vec++;
        if ({ld_ready, pe_clr, busy, done} !== 4'b0000 || a_edge !== '0 || b_edge !== '0) begin
            n_err++;
            $display("FAIL reset_hold: rdy/clr/busy/done=%b a=%h b=%h, required 0000 0 0",
                     {ld_ready, pe_clr, busy, done}, a_edge, b_edge);
        end
        rst = 1'b1;
        step;
        n_vec++;
        if ({ld_ready, pe_clr, busy, done} !== 4'b1000 || a_edge !== '0 || b_edge !== '0) begin
            n_err++;
            $display("FAIL reset_idle: rdy/clr/busy/done=%b a=%h b=%h, required 1000 0 0",
                     {ld_ready, pe_clr, busy, done}, a_edge, b_edge);
        end
        load(1'b0, 5, 0, 8'hAA);
        load(1'b1, 0, 5, 8'hBB);
        load(1'b0, 2, 7, 8'hCC);
        run(99, 99, 1'b0, 1'b0);
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_a[c] !== '0 || tr_b[c] !== '0) begin
                n_err++;
                $display("FAIL oob_index[%0d]: a=%h b=%h, required 0 0", c, tr_a[c], tr_b[c]);
            end
        end
    endtask

    task automatic test_skew;
        load_mats(0);
        run(99, 99, 1'b0, 1'b0);
        n_vec++;
        if (tr_a[2] !== 32'h00000001 || tr_b[2] !== 32'h00000001) begin
            n_err++;
            $display("FAIL skew_t0: a=%h b=%h, required 00000001 00000001", tr_a[2], tr_b[2]);
        end
        n_vec++;
        if (tr_a[5] !== 32'h31221304 || tr_b[5] !== 32'h04132231) begin
            n_err++;
            $display("FAIL skew_t3: a=%h b=%h, required 31221304 04132231", tr_a[5], tr_b[5]);
        end
        n_vec++;
        if (tr_a[8] !== 32'h34000000 || tr_b[8] !== 32'h34000000) begin
            n_err++;
            $display("FAIL skew_t6: a=%h b=%h, required 34000000 34000000", tr_a[8], tr_b[8]);
        end
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_a[c] !== exp_a(0, c) || tr_b[c] !== exp_b(0, c)) begin
                n_err++;
                $display("FAIL skew_trace[%0d]: a=%h b=%h, required %h %h",
                         c, tr_a[c], tr_b[c], exp_a(0, c), exp_b(0, c));
            end
            n_vec++;
            if ({tr_clr[c], tr_done[c], tr_busy[c], tr_rdy[c]} !==
                {c == 1, c == 13, c >= 1 && c <= 12, c >= 14}) begin
                n_err++;
                $display("FAIL skew_ctrl[%0d]: clr/done/busy/rdy=%b, required %b", c,
                         {tr_clr[c], tr_done[c], tr_busy[c], tr_rdy[c]},
                         {c == 1, c == 13, c >= 1 && c <= 12, c >= 14});
            end
        end
    endtask

    task automatic test_product;
        load_mats(1);
        run(99, 99, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_vec++;
                if (pe_c[i][j] !== 4 * i + j) begin
                    n_err++;
                    $display("FAIL prod_ident(%0d,%0d): got %0d required %0d", i, j, pe_c[i][j], 4 * i + j);
                end
            end
        end
        load_mats(2);
        run(99, 99, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_vec++;
                if (pe_c[i][j] !== 24) begin
                    n_err++;
                    $display("FAIL prod_const(%0d,%0d): got %0d required 24", i, j, pe_c[i][j]);
                end
            end
        end
    endtask

    task automatic test_gating;
        load_mats(0);
        run(99, 99, 1'b1, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            n_vec++;
            if (tr_rdy[c] !== 1'b0) begin
                n_err++;
                $display("FAIL gate_ready[%0d]: got %b required 0", c, tr_rdy[c]);
            end
        end
        run(99, 99, 1'b0, 1'b0);
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_a[c] !== exp_a(0, c) || tr_b[c] !== exp_b(0, c)) begin
                n_err++;
                $display("FAIL gate_rerun[%0d]: a=%h b=%h, required %h %h",
                         c, tr_a[c], tr_b[c], exp_a(0, c), exp_b(0, c));
            end
        end
    endtask

    task automatic test_start_busy;
        run(4, 99, 1'b0, 1'b0);
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_clr[c] !== (c == 1) || tr_done[c] !== (c == 13)) begin
                n_err++;
                $display("FAIL busy_start[%0d]: clr=%b done=%b, required %b %b",
                         c, tr_clr[c], tr_done[c], c == 1, c == 13);
            end
        end
    endtask

    task automatic test_back_to_back;
        int done_at = -1;
        run(99, 99, 1'b0, 1'b1);
        n_vec++;
        if ({tr_done[13], tr_rdy[14], tr_clr[14], tr_clr[15], tr_busy[15]} !== 5'b11011) begin
            n_err++;
            $display("FAIL b2b_relaunch: done13/rdy14/clr14/clr15/busy15=%b, required 11011",
                     {tr_done[13], tr_rdy[14], tr_clr[14], tr_clr[15], tr_busy[15]});
        end
        for (int c = NC; c <= 30; c++) begin
            step;
            if (done) done_at = c;
        end
        n_vec++;
        if (done_at !== 27) begin
            n_err++;
            $display("FAIL b2b_done: last done at cycle %0d, required 27", done_at);
        end
    endtask

    task automatic test_reset_mid;
        load_mats(1);
        run(99, 6, 1'b0, 1'b0);
        n_vec++;
        if (rst_a !== '0 || rst_b !== '0 || rst_busy !== 1'b0 || rst_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: a=%h b=%h busy=%b done=%b, required 0 0 0 0",
                     rst_a, rst_b, rst_busy, rst_done);
        end
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_done[c] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_done[%0d]: got %b required 0", c, tr_done[c]);
            end
        end
        n_vec++;
        if (tr_rdy[NC-1] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_recover: ld_ready=%b required 1", tr_rdy[NC-1]);
        end
        run(99, 99, 1'b0, 1'b0);
        for (int c = 1; c < NC; c++) begin
            n_vec++;
            if (tr_a[c] !== '0 || tr_b[c] !== '0) begin
                n_err++;
                $display("FAIL rst_cleared[%0d]: a=%h b=%h, required 0 0", c, tr_a[c], tr_b[c]);
            end
        end
        load_mats(1);
        run(99, 99, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                n_vec++;
                if (pe_c[i][j] !== 4 * i + j) begin
                    n_err++;
                    $display("FAIL rst_reprod(%0d,%0d): got %0d required %0d", i, j, pe_c[i][j], 4 * i + j);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_skew;
        test_product;
        test_gating;
        test_start_busy;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
